// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types, defaults and edge-strobe decode for the SPI clock path
package spi_pkg;

  // Default widths, shared with the SPI master top
  localparam int DEF_DIV_W  = 8;
  localparam int DEF_BITS_W = 6;

  // Burst sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    GUARD = 2'd2
  } sclk_state_t;

  // Decode which strobe an SCLK edge carries; result is {sample, shift}.
  // With CPHA=0 the final trailing edge carries no shift because the last
  // bit has already been presented on the line.
  function automatic logic [1:0] edge_strobes(input logic cpha,
                                              input logic leading,
                                              input logic last_edge);
    logic sample;
    logic shift;
    if (cpha) begin
      sample = !leading;
      shift  = leading;
    end else begin
      sample = leading;
      shift  = !leading && !last_edge;
    end
    return {sample, shift};
  endfunction

endpackage

// File: rtl/spi_sclk_gen_if.sv
// rtl/spi_sclk_gen_if.sv - control/config and strobe bundle between SPI control FSM and clock generator
interface spi_sclk_gen_if #(
  parameter int DIV_W  = spi_pkg::DEF_DIV_W,
  parameter int BITS_W = spi_pkg::DEF_BITS_W
) ();

  logic              start;
  logic              abort;
  logic [DIV_W-1:0]  div;
  logic [BITS_W-1:0] nbits;
  logic              cpol;
  logic              cpha;
  logic              sclk;
  logic              busy;
  logic              sample_stb;
  logic              shift_stb;
  logic              done;

  // Control FSM side: requests bursts and consumes status
  modport master (
    output start, abort, div, nbits, cpol, cpha,
    input  sclk, busy, sample_stb, shift_stb, done
  );

  // Clock generator side
  modport slave (
    input  start, abort, div, nbits, cpol, cpha,
    output sclk, busy, sample_stb, shift_stb, done
  );

endinterface

// File: rtl/spi_half_period_ctr.sv
// rtl/spi_half_period_ctr.sv - loadable down-counter that reloads itself and ticks at zero
module spi_half_period_ctr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] reload_val,
  output logic         tick
);

  logic [W-1:0] cnt;

  // tick marks the cycle in which the counter sits at zero and will reload
  assign tick = en && (cnt == '0);

  // Count down while enabled; an explicit load overrides counting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      if (cnt == '0) begin
        cnt <= reload_val;
      end else begin
        cnt <= cnt - W'(1);
      end
    end
  end

endmodule

// File: rtl/spi_sclk_gen.sv
// rtl/spi_sclk_gen.sv - programmable SPI SCLK burst generator with per-edge sample/shift strobes
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int DIV_W  = DEF_DIV_W,
  parameter int BITS_W = DEF_BITS_W
) (
  input  logic                clk,
  input  logic                rst,
  spi_sclk_gen_if.slave       bus
);

  sclk_state_t        state;
  logic [DIV_W-1:0]   div_l;
  logic [BITS_W-1:0]  nbits_l;
  logic               cpol_l;
  logic               cpha_l;
  logic [BITS_W:0]    edge_cnt;

  logic               sclk_r;
  logic               busy_r;
  logic               sample_r;
  logic               shift_r;
  logic               done_r;

  logic               accept;
  logic               cancel;
  logic               finish;
  logic               tick;
  logic               ctr_load;
  logic [DIV_W-1:0]   ctr_load_val;
  logic               ctr_en;
  logic [BITS_W:0]    edge_nxt;
  logic               last_edge;
  logic               leading;

  // abort beats a simultaneous start; nbits=0 requests are ignored
  assign accept = (state == IDLE) && bus.start && !bus.abort && (bus.nbits != '0);
  assign cancel = (state != IDLE) && bus.abort;
  assign finish = (state == GUARD) && done_r && !bus.abort;

  assign edge_nxt  = edge_cnt + (BITS_W+1)'(1);
  assign last_edge = (edge_nxt == {nbits_l, 1'b0});
  assign leading   = edge_nxt[0];

  // The accept cycle counts as the first cycle of the first half-period, so the
  // counter starts at div-1; with div=0 the first edge is taken in the accept
  // cycle itself and the counter starts at 0 for the second edge.
  assign ctr_load     = accept || cancel || finish;
  assign ctr_load_val = (accept && (bus.div != '0)) ? (bus.div - DIV_W'(1)) : '0;
  assign ctr_en       = (state != IDLE);

  spi_half_period_ctr #(.W(DIV_W)) u_hp_ctr (
    .clk        (clk),
    .rst        (rst),
    .load       (ctr_load),
    .load_val   (ctr_load_val),
    .en         (ctr_en),
    .reload_val (div_l),
    .tick       (tick)
  );

  // Burst sequencer: latches config, walks the edges, then a guard half-period
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      div_l    <= '0;
      nbits_l  <= '0;
      cpol_l   <= 1'b0;
      cpha_l   <= 1'b0;
      edge_cnt <= '0;
      sclk_r   <= 1'b0;
      busy_r   <= 1'b0;
      sample_r <= 1'b0;
      shift_r  <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      sample_r <= 1'b0;
      shift_r  <= 1'b0;
      done_r   <= 1'b0;
      case (state)
        IDLE: begin
          sclk_r <= bus.cpol;
          if (accept) begin
            div_l   <= bus.div;
            nbits_l <= bus.nbits;
            cpol_l  <= bus.cpol;
            cpha_l  <= bus.cpha;
            busy_r  <= 1'b1;
            state   <= RUN;
            if (bus.div == '0) begin
              sclk_r   <= ~bus.cpol;
              edge_cnt <= (BITS_W+1)'(1);
              {sample_r, shift_r} <= edge_strobes(bus.cpha, 1'b1, 1'b0);
            end else begin
              edge_cnt <= '0;
            end
          end
        end
        RUN: begin
          if (bus.abort) begin
            state    <= IDLE;
            busy_r   <= 1'b0;
            sclk_r   <= bus.cpol;
            edge_cnt <= '0;
          end else if (tick) begin
            sclk_r   <= ~sclk_r;
            edge_cnt <= edge_nxt;
            {sample_r, shift_r} <= edge_strobes(cpha_l, leading, last_edge);
            if (last_edge) begin
              state <= GUARD;
            end
          end
        end
        GUARD: begin
          if (bus.abort || done_r) begin
            state    <= IDLE;
            busy_r   <= 1'b0;
            sclk_r   <= bus.abort ? bus.cpol : cpol_l;
            edge_cnt <= '0;
          end else if (tick) begin
            done_r <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          busy_r   <= 1'b0;
          edge_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.sclk       = sclk_r;
  assign bus.busy       = busy_r;
  assign bus.sample_stb = sample_r;
  assign bus.shift_stb  = shift_r;
  assign bus.done       = done_r;

endmodule
